// File: rtl/alu_mult_seq.sv
// alu_mult_seq: sequential shift-add unsigned multiplier issuing one ADDU per step to an external ALU.
// Optional MULT_EARLY_TERM_EN stops as soon as the remaining multiplier bits are all zero.
`ifndef W_CPU
`define W_CPU 32
`endif
`ifndef W_OPCODE
`define W_OPCODE 4
`endif
`ifndef ADDU
`define ADDU 4'd1
`endif
module alu_mult_seq #(
   parameter int W     = `W_CPU,
   parameter int CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [W-1:0]         req_a,
   input  logic [W-1:0]         req_b,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [W-1:0]         hi,
   output logic [W-1:0]         lo,
   output logic [`W_OPCODE-1:0] alu_op,
   output logic [W-1:0]         alu_a,
   output logic [W-1:0]         alu_b,
   input  logic [W-1:0]         alu_r,
   input  logic                 alu_carry
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nxt;
   // top bit of the 2W+1 product register is always zero after a shift, so it is not stored
   logic [2*W-1:0] p, p_nxt, prod;
   logic [W-1:0] mcand;
   logic [CNT_W-1:0] cnt;
   logic last;
   assign req_ready  = state == IDLE;
   assign resp_valid = state == DONE;
   assign alu_op     = `ADDU;
   assign alu_a      = state == CALC ? p[2*W-1:W] : '0;
   assign alu_b      = (state == CALC && p[0]) ? mcand : '0;
   assign p_nxt      = {alu_carry, alu_r, p[W-1:1]};
`ifdef MULT_EARLY_TERM_EN
   // unconsumed multiplier bits sit in the low W-1-cnt bits of the shifted register
   assign last = (p_nxt[W-1:0] << (cnt + 1'b1)) == '0;
   assign prod = p_nxt >> (CNT_W'(W - 1) - cnt);
`else
   assign last = cnt == CNT_W'(W - 1);
   assign prod = p_nxt;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      if (state == IDLE && req_valid) state_nxt = CALC;
      if (state == CALC && last) state_nxt = DONE;
      if (state == DONE && resp_ready) state_nxt = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         p     <= '0;
         mcand <= '0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else if (req_valid && req_ready) begin
         p     <= {{W{1'b0}}, req_b};
         mcand <= req_a;
         cnt   <= '0;
      end else if (state == CALC) begin
         p   <= p_nxt;
         cnt <= cnt + 1'b1;
         if (last) {hi, lo} <= prod;
      end
endmodule

// File: tb/tb_alu_mult_seq.sv
// tb_alu_mult_seq: directed scoreboard bench for alu_mult_seq with a behavioural ADDU ALU.
module tb_alu_mult_seq;
   localparam int W = 32;
   logic clk = 0, rst_n = 0, req_valid = 0, resp_ready = 1;
   logic [W-1:0] req_a = '0, req_b = '0, hi, lo, alu_a, alu_b, alu_r;
   logic req_ready, resp_valid, alu_carry, pv = 0;
   logic [`W_OPCODE-1:0] alu_op;
   typedef struct {logic [2*W-1:0] prod; int acc; int lat;} exp_t;
   exp_t sb[$];
   int cyc = 0, n_chk = 0, n_pass = 0;

   alu_mult_seq #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .hi(hi), .lo(lo), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_r(alu_r), .alu_carry(alu_carry)
   );

   assign {alu_carry, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic int lat(logic [W-1:0] b);
      int n = W;
`ifdef MULT_EARLY_TERM_EN
      n = 1;
      for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
`endif
      return n;
   endfunction

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && resp_valid && !pv) begin
            if (sb.size() == 0) chk("spurious resp_valid", {63'd0, resp_valid}, 64'd0);
            else begin
               e = sb.pop_front();
               chk("product", {hi, lo}, e.prod);
               chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
         end
         pv = resp_valid;
      end
   end

   task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic [2*W-1:0] prod);
      int t = 0;
      @(negedge clk);
      req_a = a; req_b = b; req_valid = 1;
      while (!req_ready && t < 300) begin @(negedge clk); t++; end
      if (!req_ready) chk("req_ready timeout", {63'd0, req_ready}, 64'd1);
      sb.push_back('{prod, cyc + 1, lat(b)});
      @(posedge clk); #1 req_valid = 0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!(sb.size() == 0 && req_ready && !resp_valid) && t < 300) begin @(negedge clk); t++; end
      chk("back to idle", {63'd0, req_ready}, 64'd1);
      chk("scoreboard drained", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int t, t0, acc;
      #12;
      chk("rst req_ready", {63'd0, req_ready}, 64'd1);
      chk("rst resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("rst hi/lo", {hi, lo}, 64'd0);
      chk("rst alu_a/b", {alu_a, alu_b}, 64'd0);
      chk("rst alu_op", 64'(alu_op), 64'(`ADDU));
      @(negedge clk); rst_n = 1;
      issue(32'd3, 32'd5, 64'd15); wait_idle();
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001); wait_idle();
      issue(32'h12345678, 32'd0, 64'd0); wait_idle();
      issue(32'h80000000, 32'd2, 64'h00000001_00000000); wait_idle();
      resp_ready = 0;
      issue(32'd6, 32'd7, 64'd42);
      t = 0;
      while (!resp_valid && t < 300) begin @(negedge clk); t++; end
      chk("bp resp_valid rise", {63'd0, resp_valid}, 64'd1);
      req_a = 32'd11; req_b = 32'd13; req_valid = 1;
      repeat (10) begin
         @(negedge clk);
         chk("bp resp_valid held", {63'd0, resp_valid}, 64'd1);
         chk("bp hi/lo held", {hi, lo}, 64'd42);
         chk("bp req_ready low", {63'd0, req_ready}, 64'd0);
      end
      resp_ready = 1; t0 = cyc; t = 0;
      while (!req_ready && t < 300) begin @(negedge clk); t++; end
      sb.push_back('{64'd143, cyc + 1, lat(32'd13)});
      chk("accept after handshake", 64'(cyc + 1), 64'(t0 + 2));
      @(posedge clk); #1 req_valid = 0;
      wait_idle();
      issue(32'd7, 32'd9, 64'd63);
      acc = sb[$].acc;
      while (cyc < acc + 10) @(negedge clk);
      rst_n = 0; #1;
      chk("abort req_ready", {63'd0, req_ready}, 64'd1);
      chk("abort resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("abort hi/lo", {hi, lo}, 64'd0);
      chk("abort alu_a/b", {alu_a, alu_b}, 64'd0);
      void'(sb.pop_back());
      @(negedge clk); rst_n = 1;
      repeat (40) @(negedge clk);
      chk("no resp after abort", {63'd0, resp_valid}, 64'd0);
      issue(32'd7, 32'd9, 64'd63); wait_idle();
      issue(32'd1, 32'h80000000, 64'h00000000_80000000); wait_idle();
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
